// File: rtl/mem_access_router_pkg.sv
// Shared types for the memory access router: access widths, FSM states and mcause codes.
package mem_pkg;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10
  } width_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DECIDE,
    S_C_REQ,
    S_C_WAIT,
    S_U_REQ,
    S_U_WAIT,
    S_RESP
  } router_state_e;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  // Reserved width 2'b11 counts as misaligned so it can never reach memory.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lsb);
    logic mis;
    case (width_e'(width))
      W_BYTE:  mis = 1'b0;
      W_HALF:  mis = lsb[0];
      W_WORD:  mis = |lsb;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_router_if.sv
// Bundle of the router's LSU, PMA-checker and downstream memory handshakes.
// master = router side, slave = LSU / checker / memory side.
interface mem_access_router_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_width;
  logic [28:0] req_paddr;
  logic [31:0] req_wdata;

  logic        chk_read;
  logic        chk_write;
  logic [1:0]  chk_width;
  logic [16:0] chk_ppn;
  logic        chk_cacheable;
  logic        chk_error;

  logic [28:0] mem_addr;
  logic        mem_write;
  logic [1:0]  mem_width;
  logic [31:0] mem_wdata;

  logic        cache_valid;
  logic        cache_ready;
  logic        cache_rvalid;
  logic        unc_valid;
  logic        unc_ready;
  logic        unc_rvalid;
  logic [31:0] rdata;

  logic        resp_valid;
  logic        resp_ready;
  logic        resp_fault;
  logic [3:0]  resp_cause;
  logic [31:0] resp_rdata;

  modport master (
    input  req_valid, req_write, req_width, req_paddr, req_wdata,
    output req_ready,
    output chk_read, chk_write, chk_width, chk_ppn,
    input  chk_cacheable, chk_error,
    output mem_addr, mem_write, mem_width, mem_wdata,
    output cache_valid, input cache_ready, cache_rvalid,
    output unc_valid, input unc_ready, unc_rvalid,
    input  rdata,
    output resp_valid, resp_fault, resp_cause, resp_rdata,
    input  resp_ready
  );

  modport slave (
    output req_valid, req_write, req_width, req_paddr, req_wdata,
    input  req_ready,
    input  chk_read, chk_write, chk_width, chk_ppn,
    output chk_cacheable, chk_error,
    input  mem_addr, mem_write, mem_width, mem_wdata,
    input  cache_valid, output cache_ready, cache_rvalid,
    input  unc_valid, output unc_ready, unc_rvalid,
    output rdata,
    input  resp_valid, resp_fault, resp_cause, resp_rdata,
    output resp_ready
  );

endinterface

// File: rtl/mem_access_router.sv
// Single-outstanding LSU access router: PMA check, then fault or route to cache / uncached port.
// Optional alignment check enabled by defining MEM_ROUTER_MISALIGN_CHECK_EN.
module mem_access_router
  import mem_pkg::*;
#(
  parameter int unsigned UNC_TIMEOUT = 255
) (
  input  logic                 clk_core,
  input  logic                 reset_n,
  mem_access_router_if.master  bus
);

  localparam int TW = (UNC_TIMEOUT < 1) ? 1 : $clog2(UNC_TIMEOUT + 1);

  router_state_e r_state, w_next;

  logic          r_write;
  logic [1:0]    r_width;
  logic [28:0]   r_paddr;
  logic [31:0]   r_wdata;
  logic          r_fault;
  logic [3:0]    r_cause;
  logic [31:0]   r_rdata;
  logic [TW-1:0] r_tmo;

  logic          w_accept;
  logic          w_misalign;
  logic          w_tmo_hit;
  logic          w_set_resp;
  logic          w_fault;
  logic [3:0]    w_cause;
  logic [31:0]   w_rdata;
  logic [31:0]   w_ld_data;

`ifdef MEM_ROUTER_MISALIGN_CHECK_EN
  assign w_misalign = is_misaligned(r_width, r_paddr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_tmo_hit = (UNC_TIMEOUT != 0) && (r_tmo >= TW'(UNC_TIMEOUT));
  assign w_ld_data = r_write ? 32'd0 : bus.rdata;

  always_comb begin
    w_next     = r_state;
    w_set_resp = 1'b0;
    w_fault    = 1'b0;
    w_cause    = 4'd0;
    w_rdata    = 32'd0;
    case (r_state)
      S_IDLE:   if (bus.req_valid) w_next = S_CHECK;
      S_CHECK: begin
        // Checker still sees this cycle; its result is simply never consumed.
        if (w_misalign) begin
          w_next     = S_RESP;
          w_set_resp = 1'b1;
          w_fault    = 1'b1;
          w_cause    = r_write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
        end else begin
          w_next = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (bus.chk_error) begin
          w_next     = S_RESP;
          w_set_resp = 1'b1;
          w_fault    = 1'b1;
          w_cause    = r_write ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
        end else begin
          w_next = bus.chk_cacheable ? S_C_REQ : S_U_REQ;
        end
      end
      S_C_REQ: begin
        if (bus.cache_ready) begin
          if (bus.cache_rvalid) begin
            w_next     = S_RESP;
            w_set_resp = 1'b1;
            w_rdata    = w_ld_data;
          end else begin
            w_next = S_C_WAIT;
          end
        end
      end
      S_C_WAIT: begin
        if (bus.cache_rvalid) begin
          w_next     = S_RESP;
          w_set_resp = 1'b1;
          w_rdata    = w_ld_data;
        end
      end
      S_U_REQ: begin
        if (bus.unc_ready) begin
          if (bus.unc_rvalid) begin
            w_next     = S_RESP;
            w_set_resp = 1'b1;
            w_rdata    = w_ld_data;
          end else begin
            w_next = S_U_WAIT;
          end
        end
      end
      S_U_WAIT: begin
        // A completion in the timeout cycle still wins over the fault.
        if (bus.unc_rvalid) begin
          w_next     = S_RESP;
          w_set_resp = 1'b1;
          w_rdata    = w_ld_data;
        end else if (w_tmo_hit) begin
          w_next     = S_RESP;
          w_set_resp = 1'b1;
          w_fault    = 1'b1;
          w_cause    = r_write ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
        end
      end
      S_RESP:   if (bus.resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_width <= 2'd0;
      r_paddr <= 29'd0;
      r_wdata <= 32'd0;
      r_fault <= 1'b0;
      r_cause <= 4'd0;
      r_rdata <= 32'd0;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_width <= bus.req_width;
        r_paddr <= bus.req_paddr;
        r_wdata <= bus.req_wdata;
        r_fault <= 1'b0;
        r_cause <= 4'd0;
        r_rdata <= 32'd0;
      end
      if (w_set_resp) begin
        r_fault <= w_fault;
        r_cause <= w_cause;
        r_rdata <= w_rdata;
      end
      // Counter spans U_REQ and U_WAIT; saturates so it cannot wrap past the limit.
      if (r_state == S_DECIDE)
        r_tmo <= '0;
      else if ((r_state == S_U_REQ || r_state == S_U_WAIT) && (r_tmo != '1))
        r_tmo <= r_tmo + 1'b1;
    end
  end

  assign bus.req_ready   = (r_state == S_IDLE);
  assign bus.chk_read    = (r_state == S_CHECK) && !r_write;
  assign bus.chk_write   = (r_state == S_CHECK) &&  r_write;
  assign bus.chk_width   = r_width;
  assign bus.chk_ppn     = r_paddr[28:12];
  assign bus.mem_addr    = r_paddr;
  assign bus.mem_write   = r_write;
  assign bus.mem_width   = r_width;
  assign bus.mem_wdata   = r_wdata;
  assign bus.cache_valid = (r_state == S_C_REQ);
  assign bus.unc_valid   = (r_state == S_U_REQ);
  assign bus.resp_valid  = (r_state == S_RESP);
  assign bus.resp_fault  = r_fault;
  assign bus.resp_cause  = r_cause;
  assign bus.resp_rdata  = r_rdata;

endmodule
